// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter.
//   state_e : controller FSM states
//   owner_e : which requester owns the outstanding transaction
//   TCNT_W  : width of the WAIT-state timeout counter
package mem_arb_pkg;
  localparam int TCNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;
endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant logic.
//   clock, reset : rising-edge clock, synchronous active-low reset
//   req[1:0]     : bit 0 = instruction requester, bit 1 = data requester
//   advance      : the granted request is being accepted this cycle
//   grant[1:0]   : one-hot grant (zero when nobody requests)
module rr_arbiter_2
  import mem_arb_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  owner_e prio_q, prio_d;

  always_comb begin
    grant  = 2'b00;
    prio_d = prio_q;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (prio_q == OWNER_D) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    // Only a contested grant moves the pointer: the loser goes first next time.
    if (advance && req == 2'b11)
      prio_d = (prio_q == OWNER_D) ? OWNER_I : OWNER_D;
  end

  always_ff @(posedge clock) begin
    if (!reset) prio_q <= OWNER_D;
    else        prio_q <= prio_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory command port between an instruction-fetch and a data
// requester, one transaction outstanding at a time.
//   i_*           : instruction read request / accept / response
//   d_*           : data read/write request / accept / response
//   m_*           : shared memory command (out) and response (in)
//   timeout_error : sticky, set when a read gets no m_valid in time
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_read,
  input  logic [ADDRESS_BITS-1:0] i_address,
  output logic                    i_ready,
  output logic [DATA_WIDTH-1:0]   i_data_out,
  output logic [ADDRESS_BITS-1:0] i_address_out,
  output logic                    i_valid,
  input  logic                    d_read,
  input  logic                    d_write,
  input  logic [DATA_WIDTH/8-1:0] d_byte_en,
  input  logic [ADDRESS_BITS-1:0] d_address,
  input  logic [DATA_WIDTH-1:0]   d_data_in,
  output logic                    d_ready,
  output logic [DATA_WIDTH-1:0]   d_data_out,
  output logic [ADDRESS_BITS-1:0] d_address_out,
  output logic                    d_valid,
  output logic                    m_read,
  output logic                    m_write,
  output logic [DATA_WIDTH/8-1:0] m_byte_en,
  output logic [ADDRESS_BITS-1:0] m_address,
  output logic [DATA_WIDTH-1:0]   m_data_in,
  input  logic [DATA_WIDTH-1:0]   m_data_out,
  input  logic [ADDRESS_BITS-1:0] m_address_out,
  input  logic                    m_valid,
  input  logic                    m_ready,
  output logic                    timeout_error
);
  localparam int          BE_W    = DATA_WIDTH / 8;
  localparam logic [31:0] TMO_LIM = TIMEOUT_CYCLES;

  state_e                  state_q, state_d;
  owner_e                  owner_q, owner_d;
  logic                    wr_q, wr_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [BE_W-1:0]         be_q, be_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [TCNT_W-1:0]       tcnt_q, tcnt_d;
  logic                    terr_q, terr_d;
  logic                    i_valid_q, i_valid_d, d_valid_q, d_valid_d;
  logic [DATA_WIDTH-1:0]   i_data_q, i_data_d, d_data_q, d_data_d;
  logic [ADDRESS_BITS-1:0] i_addr_q, i_addr_d, d_addr_q, d_addr_d;

  logic [1:0]  grant;
  logic [31:0] tcnt_inc;

  rr_arbiter_2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     ({d_read | d_write, i_read}),
    .advance (state_q == IDLE),
    .grant   (grant)
  );

  assign i_ready  = (state_q == IDLE) & grant[0];
  assign d_ready  = (state_q == IDLE) & grant[1];
  assign tcnt_inc = 32'(tcnt_q) + 32'd1;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    tcnt_d    = tcnt_q;
    terr_d    = terr_q;
    i_valid_d = 1'b0;
    d_valid_d = 1'b0;
    i_data_d  = i_data_q;
    i_addr_d  = i_addr_q;
    d_data_d  = d_data_q;
    d_addr_d  = d_addr_q;
    case (state_q)
      IDLE: begin
        if (d_ready) begin
          owner_d = OWNER_D;
          wr_d    = d_write;          // read+write together counts as a write
          addr_d  = d_address;
          be_d    = d_byte_en;
          wdata_d = d_data_in;
          state_d = ISSUE;
        end else if (i_ready) begin
          owner_d = OWNER_I;
          wr_d    = 1'b0;
          addr_d  = i_address;
          be_d    = '1;
          wdata_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (m_ready) begin
          if (wr_q) begin
            state_d = IDLE;
          end else begin
            state_d = WAIT;
            tcnt_d  = '0;
          end
        end
      end
      WAIT: begin
        if (m_valid) begin
          if (owner_q == OWNER_D) begin
            d_valid_d = 1'b1;
            d_data_d  = m_data_out;
            d_addr_d  = m_address_out;
          end else begin
            i_valid_d = 1'b1;
            i_data_d  = m_data_out;
            i_addr_d  = m_address_out;
          end
          state_d = IDLE;
        end else begin
          if (tcnt_q != '1) tcnt_d = tcnt_q + TCNT_W'(1);
          // This cycle completes TIMEOUT_CYCLES cycles of waiting.
          if (tcnt_inc >= TMO_LIM) begin
            terr_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= OWNER_D;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      tcnt_q    <= '0;
      terr_q    <= 1'b0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      i_data_q  <= '0;
      i_addr_q  <= '0;
      d_data_q  <= '0;
      d_addr_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      tcnt_q    <= tcnt_d;
      terr_q    <= terr_d;
      i_valid_q <= i_valid_d;
      d_valid_q <= d_valid_d;
      i_data_q  <= i_data_d;
      i_addr_q  <= i_addr_d;
      d_data_q  <= d_data_d;
      d_addr_q  <= d_addr_d;
    end
  end

  assign m_read        = (state_q == ISSUE) & ~wr_q;
  assign m_write       = (state_q == ISSUE) &  wr_q;
  assign m_byte_en     = be_q;
  assign m_address     = addr_q;
  assign m_data_in     = wdata_q;
  assign i_valid       = i_valid_q;
  assign i_data_out    = i_data_q;
  assign i_address_out = i_addr_q;
  assign d_valid       = d_valid_q;
  assign d_data_out    = d_data_q;
  assign d_address_out = d_addr_q;
  assign timeout_error = terr_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        i_read = 1'b0;
  logic [31:0] i_address = '0;
  logic        i_ready, i_valid;
  logic [31:0] i_data_out, i_address_out;
  logic        d_read = 1'b0, d_write = 1'b0;
  logic [3:0]  d_byte_en = '0;
  logic [31:0] d_address = '0, d_data_in = '0;
  logic        d_ready, d_valid;
  logic [31:0] d_data_out, d_address_out;
  logic        m_read, m_write;
  logic [3:0]  m_byte_en;
  logic [31:0] m_address, m_data_in;
  logic [31:0] m_data_out = '0, m_address_out = '0;
  logic        m_valid = 1'b0, m_ready = 1'b1;
  logic        timeout_error;

  int checks = 0;
  int errors = 0;

  typedef struct { logic own_d; logic [31:0] data; logic [31:0] addr; } exp_t;
  exp_t exp_q[$];
  logic acc_q[$];

  int mem_lat  = 2;
  bit mem_drop = 1'b0;

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDRESS_BITS(32), .TIMEOUT_CYCLES(8)) dut (
    .clock(clock), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_ready(i_ready),
    .i_data_out(i_data_out), .i_address_out(i_address_out), .i_valid(i_valid),
    .d_read(d_read), .d_write(d_write), .d_byte_en(d_byte_en), .d_address(d_address),
    .d_data_in(d_data_in), .d_ready(d_ready), .d_data_out(d_data_out),
    .d_address_out(d_address_out), .d_valid(d_valid),
    .m_read(m_read), .m_write(m_write), .m_byte_en(m_byte_en), .m_address(m_address),
    .m_data_in(m_data_in), .m_data_out(m_data_out), .m_address_out(m_address_out),
    .m_valid(m_valid), .m_ready(m_ready), .timeout_error(timeout_error)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Memory model: answers a transferred read mem_lat cycles after m_read.
  initial begin
    logic        xfer, pend;
    logic [31:0] xa, pa;
    int          cnt;
    pend = 1'b0; cnt = 0; pa = '0;
    forever begin
      @(negedge clock);
      xfer = m_read && m_ready && reset;
      xa   = m_address;
      @(posedge clock); #1;
      m_valid = 1'b0;
      if (xfer && !mem_drop) begin pend = 1'b1; cnt = mem_lat - 1; pa = xa; end
      if (pend) begin
        if (cnt == 0) begin
          m_valid = 1'b1; m_data_out = mem_rd(pa); m_address_out = pa; pend = 1'b0;
        end else cnt--;
      end
    end
  end

  // Scoreboard consumer and accept recorder.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (i_valid || d_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: i_valid=%0b d_valid=%0b, none expected", i_valid, d_valid);
        end else begin
          e = exp_q.pop_front();
          if (e.own_d && !(d_valid && !i_valid && d_data_out === e.data && d_address_out === e.addr)) begin
            errors++;
            $display("FAIL d_response: d_valid=%0b i_valid=%0b data=%h addr=%h, expected data=%h addr=%h",
                     d_valid, i_valid, d_data_out, d_address_out, e.data, e.addr);
          end
          if (!e.own_d && !(i_valid && !d_valid && i_data_out === e.data && i_address_out === e.addr)) begin
            errors++;
            $display("FAIL i_response: i_valid=%0b d_valid=%0b data=%h addr=%h, expected data=%h addr=%h",
                     i_valid, d_valid, i_data_out, i_address_out, e.data, e.addr);
          end
        end
      end
      if (i_ready && i_read) acc_q.push_back(1'b0);
      if (d_ready && (d_read || d_write)) acc_q.push_back(1'b1);
    end
  end

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clock);
      if ((i_ready && i_read) || (d_ready && (d_read || d_write))) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clock);
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    @(negedge clock);
    checks++;
    if ({i_valid, d_valid, m_read, m_write, timeout_error, i_ready, d_ready} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b, expected 0000000",
        {i_valid, d_valid, m_read, m_write, timeout_error, i_ready, d_ready});
    end
    checks++;
    if ({m_byte_en, m_address, m_data_in} !== 68'h0) begin
      errors++; $display("FAIL reset_mcmd: be=%h addr=%h data=%h, expected 0", m_byte_en, m_address, m_data_in);
    end
    checks++;
    if ({i_data_out, i_address_out, d_data_out, d_address_out} !== 128'h0) begin
      errors++; $display("FAIL reset_resp: %h %h %h %h, expected 0", i_data_out, i_address_out, d_data_out, d_address_out);
    end
    tick(); reset = 1'b1;
  endtask

  task automatic test_ifetch();
    bit ok; int lat_n;
    mem_lat = 2;
    i_read = 1'b1; i_address = 32'h100;
    exp_q.push_back('{1'b0, 32'hDEADBEEF, 32'h100});
    wait_accept(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ifetch_accept: no accept, expected i_ready"); end
    lat_n = -1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 1) i_read = 1'b0;
      @(negedge clock);
      if (n == 1) begin
        checks++;
        if ({m_read, m_write, m_byte_en, m_address, m_data_in} !== {2'b10, 4'hF, 32'h100, 32'h0}) begin
          errors++; $display("FAIL ifetch_cmd: rd=%b wr=%b be=%h addr=%h data=%h, expected 1 0 f 100 0",
                             m_read, m_write, m_byte_en, m_address, m_data_in);
        end
      end
      if (i_valid) begin lat_n = n; break; end
    end
    checks++;
    if (lat_n != 4) begin errors++; $display("FAIL ifetch_latency: got %0d, expected 4", lat_n); end
    tick();
    @(negedge clock);
    checks++;
    if (i_valid !== 1'b0 || i_data_out !== 32'hDEADBEEF) begin
      errors++; $display("FAIL ifetch_hold: valid=%b data=%h, expected 0 deadbeef", i_valid, i_data_out);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    mem_lat = 1;
    acc_q.delete();
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back('{1'b1, mem_rd(32'h300), 32'h300});
      exp_q.push_back('{1'b0, mem_rd(32'h400), 32'h400});
    end
    tick();
    d_read = 1'b1; d_address = 32'h300; i_read = 1'b1; i_address = 32'h400;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (acc_q.size() >= 4) begin ok = 1'b1; break; end
    end
    tick();
    d_read = 1'b0; i_read = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_progress: %0d accepts, expected 4", acc_q.size()); end
    else begin
      checks++;
      if ({acc_q[0], acc_q[1], acc_q[2], acc_q[3]} !== 4'b1010) begin
        errors++; $display("FAIL rr_order: got %b, expected 1010 (D I D I)",
                           {acc_q[0], acc_q[1], acc_q[2], acc_q[3]});
      end
    end
    wait_drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rr_drain: %0d responses missing, expected 0", exp_q.size()); end
  endtask

  task automatic test_write_stall();
    bit ok; int wcnt; bit stable;
    tick();
    m_ready = 1'b0;
    d_write = 1'b1; d_address = 32'h200; d_byte_en = 4'h3; d_data_in = 32'h1234;
    wait_accept(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL wr_accept: no accept, expected d_ready"); end
    wcnt = 0; stable = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) d_write = 1'b0;
      if (c == 4) m_ready = 1'b1;
      @(negedge clock);
      if (m_write) begin
        wcnt++;
        if ({m_read, m_byte_en, m_address, m_data_in} !== {1'b0, 4'h3, 32'h200, 32'h1234}) stable = 1'b0;
      end
    end
    checks++;
    if (wcnt != 4) begin errors++; $display("FAIL wr_hold_cycles: got %0d, expected 4", wcnt); end
    checks++;
    if (!stable) begin errors++; $display("FAIL wr_cmd_stable: got unstable command, expected be=3 addr=200 data=1234"); end
  endtask

  task automatic test_timeout();
    bit ok;
    tick();
    mem_drop = 1'b1;
    d_read = 1'b1; d_address = 32'h500;
    wait_accept(ok);
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (n == 1) d_read = 1'b0;
      @(negedge clock);
      if (n == 9) begin
        checks++;
        if (timeout_error !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b, expected 0", timeout_error); end
      end
      if (n == 10) begin
        checks++;
        if (timeout_error !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b, expected 1", timeout_error); end
      end
    end
    mem_drop = 1'b0;
    tick();
    i_read = 1'b1; i_address = 32'h600;
    exp_q.push_back('{1'b0, mem_rd(32'h600), 32'h600});
    wait_accept(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_next_accept: no accept, expected i_ready"); end
    tick(); i_read = 1'b0;
    wait_drain(ok);
    checks++;
    if (!ok || timeout_error !== 1'b1) begin
      errors++; $display("FAIL timeout_next_serve: drained=%b sticky=%b, expected 1 1", ok, timeout_error);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    mem_lat = 4;
    tick();
    d_read = 1'b1; d_address = 32'h700;
    wait_accept(ok);
    tick(); d_read = 1'b0;
    tick(); reset = 1'b0;
    tick(); reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({i_valid, d_valid, m_read, m_write, timeout_error} !== 5'b0 ||
        {i_data_out, i_address_out, d_data_out, d_address_out, m_address, m_byte_en} !== 164'h0) begin
      errors++; $display("FAIL midreset_zero: ctrl=%b idata=%h daddr=%h maddr=%h, expected all 0",
        {i_valid, d_valid, m_read, m_write, timeout_error}, i_data_out, d_address_out, m_address);
    end
    repeat (6) tick();
    @(negedge clock);
    checks++;
    if ({d_data_out, d_address_out} !== 64'h0) begin
      errors++; $display("FAIL midreset_stray: data=%h addr=%h, expected 0 0", d_data_out, d_address_out);
    end
  endtask

  task automatic test_rw_both();
    bit ok; bit saw_rd;
    mem_lat = 1;
    tick();
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h800; d_byte_en = 4'hF; d_data_in = 32'hCAFE;
    wait_accept(ok);
    tick(); d_read = 1'b0; d_write = 1'b0;
    @(negedge clock);
    checks++;
    if ({m_write, m_read, m_data_in} !== {2'b10, 32'hCAFE}) begin
      errors++; $display("FAIL rw_both_cmd: wr=%b rd=%b data=%h, expected 1 0 cafe", m_write, m_read, m_data_in);
    end
    saw_rd = 1'b0;
    for (int n = 0; n < 5; n++) begin tick(); @(negedge clock); if (m_read) saw_rd = 1'b1; end
    checks++;
    if (saw_rd) begin errors++; $display("FAIL rw_both_noread: got m_read=1, expected 0"); end
  endtask

  initial begin
    test_reset();
    test_ifetch();
    test_round_robin();
    test_write_stall();
    test_timeout();
    test_reset_mid();
    test_rw_both();
    repeat (4) tick();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL final_scoreboard: %0d pending, expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory data word width.
REQ-002 SHALL have parameter ADDRESS_BITS, default 32, byte address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum WAIT cycles before abort.
REQ-004 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports i_read input 1, i_address input ADDRESS_BITS  instruction-fetch request.
REQ-007 SHALL have ports i_ready output 1, i_data_out output DATA_WIDTH, i_address_out output ADDRESS_BITS, i_valid output 1  instruction accept and response.
REQ-008 SHALL have ports d_read input 1, d_write input 1, d_byte_en input DATA_WIDTH/8, d_address input ADDRESS_BITS, d_data_in input DATA_WIDTH  data request.
REQ-009 SHALL have ports d_ready output 1, d_data_out output DATA_WIDTH, d_address_out output ADDRESS_BITS, d_valid output 1  data accept and response.
REQ-010 SHALL have ports m_read output 1, m_write output 1, m_byte_en output DATA_WIDTH/8, m_address output ADDRESS_BITS, m_data_in output DATA_WIDTH  shared memory port command.
REQ-011 SHALL have ports m_data_out input DATA_WIDTH, m_address_out input ADDRESS_BITS, m_valid input 1, m_ready input 1  shared memory port response.
REQ-012 SHALL have port timeout_error  output  1  sticky flag, read aborted by timeout.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT; at most one memory transaction outstanding.
REQ-014 In IDLE, i_ready/d_ready SHALL assert combinationally only for the requester the arbiter grants; both SHALL be low in ISSUE and WAIT.
REQ-015 Arbitration SHALL be round-robin over two requesters; after reset the data requester has priority; on a conflict the loser gets priority next time.
REQ-016 A single requester SHALL be granted immediately regardless of priority pointer.
REQ-017 On acceptance (request and ready), the block SHALL latch type, address, byte_en, data and owner, and go to ISSUE.
REQ-018 If d_read and d_write are both high, the request SHALL be treated as a write.
REQ-019 An instruction request SHALL drive m_byte_en all-ones and m_data_in zero.
REQ-020 In ISSUE, m_read or m_write SHALL assert from latched values; the command transfers in the first cycle m_ready is high; the command SHALL be held stable while m_ready is low.
REQ-021 A transferred write SHALL return to IDLE next cycle with no response pulse.
REQ-022 A transferred read SHALL enter WAIT; m_read/m_write SHALL be low in WAIT.
REQ-023 In WAIT, m_valid SHALL be captured and the owner's *_data_out/*_address_out registered, with the owner's *_valid pulsed high for exactly one cycle after m_valid; state returns to IDLE in that same cycle.
REQ-024 Minimum read latency: accept cycle 0, m_read cycle 1, m_valid cycle N, owner *_valid cycle N+1.
REQ-025 m_valid arriving in IDLE or ISSUE SHALL be ignored.
REQ-026 A 16-bit WAIT counter SHALL abort the read once it reaches TIMEOUT_CYCLES: set timeout_error, no response, return to IDLE; the counter saturates and clears on each WAIT entry.
REQ-027 Response data/address outputs SHALL hold their last value between valid pulses.

Reset
REQ-028 reset low at a clock edge SHALL force IDLE, data priority, timeout_error=0, all *_valid/m_read/m_write=0, all data/address/byte_en outputs=0.
REQ-029 Reset mid-transaction SHALL discard the transaction; a later m_valid for it SHALL be ignored.

Structure
REQ-030 Package mem_arb_pkg SHALL hold the FSM state enum, owner enum (OWNER_I, OWNER_D) and the timeout counter width constant.
REQ-031 The grant logic SHALL be sub-module rr_arbiter_2 (req[1:0], advance -> grant[1:0], priority register inside).

Verification
REQ-032 Directed: i_read at 0x100 only, memory returns 0xDEADBEEF 2 cycles after m_read -> i_valid one cycle, i_data_out=0xDEADBEEF, i_address_out=0x100.
REQ-033 Directed: i_read and d_read both high continuously -> grants D, I, D, I; neither requester starves.
REQ-034 Directed: d_write 0x200, byte_en 0x3, data 0x1234, m_ready low 3 cycles -> m_write held stable 4 cycles, m_byte_en=0x3, no d_valid.
REQ-035 Directed: read with m_valid never returned, TIMEOUT_CYCLES=8 -> timeout_error high after 8 WAIT cycles, FSM in IDLE, next request served.
REQ-036 Directed: reset low during WAIT, stray m_valid afterwards -> all outputs zero, no i_valid/d_valid pulse.
REQ-037 Directed: d_read and d_write both high -> m_write issued, no m_read.
